cci_mpf_shim_buffer_tx_sched: RTL and testbench
===============================================

// Module: cci_mpf_shim_buffer_tx_sched
// PURPOSE
//  Dequeue scheduler for a buffered AFU-side Tx shim: decides per cycle whether to pop the c0 (read) and c1 (write)
//  request FIFO heads toward the FIU-side port. Credit counters model downstream capacity; almost-full gates new work.
//  Multi-line c1 writes are never split: all credits are reserved at SOP, and the remaining beats then drain regardless
//  of almost-full. Sits between the buffer FIFOs' notEmpty/first outputs and their deq inputs.
// PARAMETERS
//  N_C0_CREDITS  8  downstream c0 request slots (>=1)
//  N_C1_CREDITS  8  downstream c1 line slots (>=4, so a 4-line write can always start)
// PORTS
//  clk            in   1   clock
//  reset          in   1   synchronous, active-high reset
//  c0_valid       in   1   c0 FIFO head valid (notEmpty)
//  c0_dn_almFull  in   1   downstream c0 almost full
//  c0_credit_ret  in   1   one c0 slot freed downstream (pulse)
//  c0_deq         out  1   pop c0 head this cycle
//  c1_valid       in   1   c1 FIFO head valid
//  c1_sop         in   1   c1 head is the first beat of a packet
//  c1_cl_len      in   2   c1 head length code: 0=1 line, 1=2 lines, 3=4 lines, 2=illegal
//  c1_dn_almFull  in   1   downstream c1 almost full
//  c1_credit_ret  in   1   one c1 line slot freed downstream (pulse)
//  c1_deq         out  1   pop c1 head this cycle
//  c0_credits     out  CW0 free c0 credits; CW0=$clog2(N_C0_CREDITS+1)
//  c1_credits     out  CW1 free c1 credits; CW1=$clog2(N_C1_CREDITS+1)
//  c1_in_packet   out  1   c1 FSM in PKT state
//  err_sticky     out  1   protocol error seen; cleared only by reset
// BEHAVIOUR
//  Reset: c0_credits=N_C0_CREDITS, c1_credits=N_C1_CREDITS, FSM=IDLE, beats_left=0, err_sticky=0; deq outs 0 while reset=1.
//  Reset applied mid-packet discards the packet state: the FSM returns to IDLE and credits return to full.
//  c0_deq = c0_valid & !c0_dn_almFull & (c0_credits!=0). Combinational; zero latency.
//  c0 credits next = c0_credits - c0_deq + c0_credit_ret. A simultaneous deq and return leaves the count unchanged.
//  c1 FSM IDLE:
//   - n = c1_cl_len+1. Grant when c1_valid & !c1_dn_almFull & c1_credits>=n.
//   - On grant: c1_deq=1 and credits -= n.
//   - If n>1: beats_left=n-1 and go to PKT. If n==1: stay in IDLE.
//   - c1_sop=0 in IDLE: set err, treat the beat as a 1-line packet (n=1).
//   - cl_len=2: set err, treat as n=1.
//  c1 FSM PKT:
//   - c1_deq = c1_valid. Ignores almFull and credits (already reserved).
//   - Each deq decrements beats_left; at beats_left==1 with deq, go to IDLE.
//   - c1_valid=0 in PKT: stall without deq, stay in PKT.
//   - c1_sop=1 in PKT: set err, consume the beat as a continuation anyway.
//  c1 credits next = c1_credits - (reservation at grant) + c1_credit_ret.
//  Credit overflow (return when count==N): set err, count saturates at N.
//  The controller never dequeues an empty FIFO. No underflow is possible by construction.
//  Outputs c0_credits, c1_credits, c1_in_packet and err_sticky are registered.
// TESTING
//  T1: reset, c0_valid=1 steady, no returns -> exactly 8 c0_deq pulses on consecutive cycles, then c0_deq=0, c0_credits=0.
//  T2: from T1, assert c0_credit_ret once -> next cycle c0_credits=1, one more c0_deq, back to 0.
//  T3: c1 4-line packet (sop=1, cl_len=3) at credits=8 -> c1_credits=4 after SOP.
//      Raise c1_dn_almFull after beat 1 -> beats 2-4 still dequeued; FSM returns to IDLE.
//  T4: c1_credits=3, head 4-line SOP -> no deq until one return. Then grant; credits go 4->0.
//  T5: 2-line packet with c1_valid gap of 3 cycles between beats -> c1_in_packet held, 2 deqs total, err_sticky=0.
//  T6: reset mid-4-line packet after beat 2 -> FSM IDLE, c1_credits=8. Next SOP accepted normally.
//      Also: sop=0 in IDLE -> err_sticky=1 and the beat is consumed as 1 line.

Source files
------------

// File: rtl/cci_mpf_shim_buffer_tx_sched.sv
// Dequeue scheduler for a buffered AFU-side Tx shim.
// Decides each cycle whether to pop the c0 (read) and c1 (write) request FIFO
// heads toward the FIU-side port. Credit counters model downstream capacity,
// and almost-full gates new work. A multi-line c1 write reserves all of its
// credits at SOP, and its remaining beats then drain regardless of almost-full.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   c0_valid, c0_dn_almFull     c0 head valid, downstream c0 almost full
//   c0_credit_ret               one c0 slot freed downstream (pulse)
//   c0_deq                      pop c0 head (combinational)
//   c1_valid, c1_sop, c1_cl_len c1 head valid, first beat, length code
//   c1_dn_almFull               downstream c1 almost full
//   c1_credit_ret               one c1 line slot freed downstream (pulse)
//   c1_deq                      pop c1 head (combinational)
//   c0_credits, c1_credits      free credits (registered)
//   c1_in_packet                c1 FSM is mid-packet (registered)
//   err_sticky                  protocol error seen, cleared by reset only
//
// state | meaning
// IDLE  | waiting for a c1 SOP; grants gated by almost-full and credits
// PKT   | draining continuation beats of a granted multi-line write
module cci_mpf_shim_buffer_tx_sched #(
  parameter int N_C0_CREDITS = 8,
  parameter int N_C1_CREDITS = 8,
  localparam int CW0 = $clog2(N_C0_CREDITS + 1),
  localparam int CW1 = $clog2(N_C1_CREDITS + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           c0_valid,
  input  logic           c0_dn_almFull,
  input  logic           c0_credit_ret,
  output logic           c0_deq,
  input  logic           c1_valid,
  input  logic           c1_sop,
  input  logic [1:0]     c1_cl_len,
  input  logic           c1_dn_almFull,
  input  logic           c1_credit_ret,
  output logic           c1_deq,
  output logic [CW0-1:0] c0_credits,
  output logic [CW1-1:0] c1_credits,
  output logic           c1_in_packet,
  output logic           err_sticky
);

  typedef enum logic {IDLE, PKT} state_t;

  state_t         state;
  logic [1:0]     beats_left;
  logic           c1_bad;
  logic [2:0]     c1_n;
  logic           c1_grant;
  logic [CW0:0]   c0_sum;
  logic [CW1:0]   c1_sum;
  logic           c0_ovf;
  logic           c1_ovf;

  always_comb begin
    c0_deq = !reset && c0_valid && !c0_dn_almFull && (c0_credits != '0);

    // A beat arriving in IDLE without SOP, or with the illegal length code,
    // is still consumed but only as a single line.
    c1_bad = !c1_sop || (c1_cl_len == 2'd2);
    c1_n   = c1_bad ? 3'd1 : ({1'b0, c1_cl_len} + 3'd1);
    c1_grant = !reset && (state == IDLE) && c1_valid && !c1_dn_almFull &&
               (c1_credits >= CW1'(c1_n));
    c1_deq = !reset && ((state == PKT) ? c1_valid : c1_grant);

    c0_sum = {1'b0, c0_credits} - (CW0+1)'(c0_deq) + (CW0+1)'(c0_credit_ret);
    c1_sum = {1'b0, c1_credits} - (c1_grant ? (CW1+1)'(c1_n) : '0)
             + (CW1+1)'(c1_credit_ret);
    c0_ovf = c0_sum > (CW0+1)'(N_C0_CREDITS);
    c1_ovf = c1_sum > (CW1+1)'(N_C1_CREDITS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      beats_left   <= '0;
      c0_credits   <= CW0'(N_C0_CREDITS);
      c1_credits   <= CW1'(N_C1_CREDITS);
      c1_in_packet <= 1'b0;
      err_sticky   <= 1'b0;
    end else begin
      c0_credits <= c0_ovf ? CW0'(N_C0_CREDITS) : c0_sum[CW0-1:0];
      c1_credits <= c1_ovf ? CW1'(N_C1_CREDITS) : c1_sum[CW1-1:0];

      if (c0_ovf || c1_ovf ||
          (c1_grant && c1_bad) ||
          ((state == PKT) && c1_valid && c1_sop))
        err_sticky <= 1'b1;

      case (state)
        IDLE: begin
          if (c1_grant && (c1_n != 3'd1)) begin
            beats_left   <= 2'(c1_n - 3'd1);
            state        <= PKT;
            c1_in_packet <= 1'b1;
          end
        end
        PKT: begin
          if (c1_deq) begin
            beats_left <= beats_left - 2'd1;
            if (beats_left == 2'd1) begin
              state        <= IDLE;
              c1_in_packet <= 1'b0;
            end
          end
        end
        default: begin
          state        <= IDLE;
          c1_in_packet <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cci_mpf_shim_buffer_tx_sched.sv
// Bench for the Tx dequeue scheduler: directed scenarios plus randomized
// traffic, every cycle compared against a credit/packet model.
module tb_cci_mpf_shim_buffer_tx_sched;
  localparam int N0 = 8;
  localparam int N1 = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       c0_valid, c0_dn_almFull, c0_credit_ret;
  logic       c1_valid, c1_sop, c1_dn_almFull, c1_credit_ret;
  logic [1:0] c1_cl_len;
  logic       c0_deq, c1_deq, c1_in_packet, err_sticky;
  logic [3:0] c0_credits, c1_credits;

  int errors = 0;
  int checks = 0;

  // model state: free credits, continuation beats still owed, error flag
  int m_c0, m_c1, m_left;
  bit m_err;
  int n_c0_deq, n_c1_deq;

  cci_mpf_shim_buffer_tx_sched #(.N_C0_CREDITS(N0), .N_C1_CREDITS(N1)) dut (
    .clk(clk), .reset(reset),
    .c0_valid(c0_valid), .c0_dn_almFull(c0_dn_almFull),
    .c0_credit_ret(c0_credit_ret), .c0_deq(c0_deq),
    .c1_valid(c1_valid), .c1_sop(c1_sop), .c1_cl_len(c1_cl_len),
    .c1_dn_almFull(c1_dn_almFull), .c1_credit_ret(c1_credit_ret),
    .c1_deq(c1_deq), .c0_credits(c0_credits), .c1_credits(c1_credits),
    .c1_in_packet(c1_in_packet), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare one cycle against the model, advance the model, move to the next
  // cycle. Inputs must already be driven for this cycle.
  task automatic tick();
    int  n;
    bit  e0, e1, bad;
    #2;
    e0  = !reset && c0_valid && !c0_dn_almFull && m_c0 > 0;
    bad = !c1_sop || c1_cl_len == 2'd2;
    n   = bad ? 1 : int'(c1_cl_len) + 1;
    if (m_left > 0) e1 = !reset && c1_valid;
    else            e1 = !reset && c1_valid && !c1_dn_almFull && m_c1 >= n;

    chk("c0_deq", int'(c0_deq), int'(e0));
    chk("c1_deq", int'(c1_deq), int'(e1));
    chk("c0_credits", int'(c0_credits), m_c0);
    chk("c1_credits", int'(c1_credits), m_c1);
    chk("c1_in_packet", int'(c1_in_packet), int'(m_left > 0));
    chk("err_sticky", int'(err_sticky), int'(m_err));
    n_c0_deq += int'(c0_deq);
    n_c1_deq += int'(c1_deq);

    if (reset) begin
      m_c0 = N0; m_c1 = N1; m_left = 0; m_err = 0;
    end else begin
      m_c0 = m_c0 - int'(e0) + int'(c0_credit_ret);
      if (m_c0 > N0) begin m_c0 = N0; m_err = 1; end
      if (m_left > 0) begin
        if (e1) begin
          m_left--;
          if (c1_sop) m_err = 1;
        end
      end else if (e1) begin
        m_c1  -= n;
        m_left = n - 1;
        if (bad) m_err = 1;
      end
      m_c1 += int'(c1_credit_ret);
      if (m_c1 > N1) begin m_c1 = N1; m_err = 1; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    c0_valid = 0; c0_dn_almFull = 0; c0_credit_ret = 0;
    c1_valid = 0; c1_sop = 0; c1_cl_len = 2'd0;
    c1_dn_almFull = 0; c1_credit_ret = 0;
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1; tick(); tick();
    reset = 0;
  endtask

  task automatic c1_beat(input bit sop, input logic [1:0] len);
    c1_valid = 1; c1_sop = sop; c1_cl_len = len;
  endtask

  initial begin
    m_c0 = 0; m_c1 = 0; m_left = 0; m_err = 0;
    reset = 1; idle_in();
    @(posedge clk); #1;
    // first cycle in reset: registered state still unknown, align the model
    m_c0 = N0; m_c1 = N1;
    @(posedge clk); #1;
    do_reset();
    chk("reset_c0_credits", int'(c0_credits), 8);
    chk("reset_c1_credits", int'(c1_credits), 8);
    chk("reset_err", int'(err_sticky), 0);

    // T1: steady c0 head drains all eight credits
    n_c0_deq = 0;
    c0_valid = 1;
    repeat (12) tick();
    chk("t1_deq_count", n_c0_deq, 8);
    chk("t1_credits", int'(c0_credits), 0);

    // T2: one return gives exactly one more dequeue
    n_c0_deq = 0;
    c0_credit_ret = 1; tick();
    c0_credit_ret = 0;
    chk("t2_credits_after_ret", int'(c0_credits), 1);
    repeat (3) tick();
    chk("t2_deq_count", n_c0_deq, 1);
    chk("t2_credits", int'(c0_credits), 0);

    // T3: 4-line write, almost-full after the first beat does not stall it
    do_reset();
    n_c1_deq = 0;
    c1_beat(1, 2'd3); tick();
    chk("t3_credits_after_sop", int'(c1_credits), 4);
    chk("t3_in_packet", int'(c1_in_packet), 1);
    c1_dn_almFull = 1; c1_beat(0, 2'd3);
    repeat (3) tick();
    chk("t3_deq_count", n_c1_deq, 4);
    chk("t3_idle", int'(c1_in_packet), 0);
    c1_dn_almFull = 0; c1_valid = 0; tick();

    // T4: 3 credits cannot start a 4-line write until one comes back
    c1_beat(1, 2'd0); tick();
    chk("t4_credits3", int'(c1_credits), 3);
    n_c1_deq = 0;
    c1_beat(1, 2'd3);
    repeat (3) tick();
    chk("t4_blocked", n_c1_deq, 0);
    c1_credit_ret = 1; tick();
    c1_credit_ret = 0;
    chk("t4_credits4", int'(c1_credits), 4);
    tick();
    chk("t4_granted", n_c1_deq, 1);
    chk("t4_credits0", int'(c1_credits), 0);
    c1_valid = 0; tick();

    // T5: gap inside a 2-line write holds the packet state
    do_reset();
    n_c1_deq = 0;
    c1_beat(1, 2'd1); tick();
    c1_valid = 0;
    repeat (3) tick();
    chk("t5_held", int'(c1_in_packet), 1);
    c1_beat(0, 2'd1); tick();
    c1_valid = 0; tick();
    chk("t5_deq_count", n_c1_deq, 2);
    chk("t5_err", int'(err_sticky), 0);
    chk("t5_idle", int'(c1_in_packet), 0);

    // T6: reset mid-packet, then a normal SOP, then an SOP-less beat
    do_reset();
    c1_beat(1, 2'd3); tick();
    c1_beat(0, 2'd3); tick();
    idle_in(); reset = 1; tick();
    reset = 0;
    chk("t6_idle", int'(c1_in_packet), 0);
    chk("t6_credits", int'(c1_credits), 8);
    c1_beat(1, 2'd0); tick();
    chk("t6_sop_ok", int'(c1_credits), 7);
    c1_beat(0, 2'd3); tick();
    c1_valid = 0; tick();
    chk("t6_err", int'(err_sticky), 1);
    chk("t6_one_line", int'(c1_credits), 6);
    chk("t6_no_packet", int'(c1_in_packet), 0);

    // overflow: returning a credit while full flags an error and saturates
    do_reset();
    c0_credit_ret = 1; tick();
    c0_credit_ret = 0; tick();
    chk("ovf_err", int'(err_sticky), 1);
    chk("ovf_sat", int'(c0_credits), 8);

    // randomized traffic; returns only for slots actually outstanding
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset         = ($urandom_range(0, 399) == 0);
      c0_valid      = ($urandom_range(0, 3) != 0);
      c0_dn_almFull = ($urandom_range(0, 5) == 0);
      c0_credit_ret = (m_c0 < N0) && ($urandom_range(0, 2) == 0);
      c1_valid      = ($urandom_range(0, 3) != 0);
      c1_dn_almFull = ($urandom_range(0, 5) == 0);
      c1_credit_ret = (m_c1 < N1) && ($urandom_range(0, 2) == 0);
      if (m_left > 0) c1_sop = ($urandom_range(0, 49) == 0);
      else            c1_sop = ($urandom_range(0, 49) != 0);
      c1_cl_len = 2'($urandom_range(0, 3));
      if (c1_cl_len == 2'd2 && $urandom_range(0, 9) != 0) c1_cl_len = 2'd3;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
